temp_log_buffer: RTL and testbench

- Downstream consumer of the UART receiver. Captures each received temperature byte and stamps it with the current digital-clock hours/minutes.
- Stores entries in a circular log (overwrite-oldest) and tracks running min/max temperature.
- Exposes a pop-style read port for a later display/host stage.
- Sits between uArtRx and any readout logic; timestamp inputs come from digiClock.

---
 rtl/temp_log_buffer_pkg.sv | 18 +
 rtl/temp_log_buffer_log_ram.sv | 35 +++
 rtl/temp_log_buffer.sv | 110 +++++++++++
 tb/tb_temp_log_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/temp_log_buffer_pkg.sv
// Shared field widths and statistic reset values for the temperature log.
package temp_log_buffer_pkg;

    localparam int TEMP_W  = 8;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int ENTRY_W = HOUR_W + MIN_W + TEMP_W;

    localparam logic [TEMP_W-1:0] MIN_INIT = 8'hFF;
    localparam logic [TEMP_W-1:0] MAX_INIT = 8'h00;

    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
        logic [TEMP_W-1:0] temp;
    } entry_t;

endpackage

// File: rtl/temp_log_buffer_log_ram.sv
// DEPTH x ENTRY_W register array: synchronous write, registered synchronous read.
module temp_log_buffer_log_ram
    import temp_log_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; it holds its value between pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/temp_log_buffer.sv
// Circular timestamped temperature log with pop read port and running min/max.
module temp_log_buffer
    import temp_log_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [TEMP_W-1:0]  rx_data,
    input  logic               rx_valid,
    input  logic [HOUR_W-1:0]  hours,
    input  logic [MIN_W-1:0]   minutes,
    input  logic               rd_req,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [AW:0]        count,
    output logic               empty,
    output logic               full,
    output logic               overflow,
    input  logic               clr_stats,
    output logic [TEMP_W-1:0]  min_temp,
    output logic [TEMP_W-1:0]  max_temp
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    function automatic logic [TEMP_W-1:0] umin(input logic [TEMP_W-1:0] a,
                                               input logic [TEMP_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [TEMP_W-1:0] umax(input logic [TEMP_W-1:0] a,
                                               input logic [TEMP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_wr, do_pop, overwrite;
    entry_t        wr_entry;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign do_wr     = rx_valid;
    assign do_pop    = rd_req && !empty;
    // A full write without a pop drops the oldest entry.
    assign overwrite = do_wr && full && !do_pop;

    assign wr_entry.hours   = hours;
    assign wr_entry.minutes = minutes;
    assign wr_entry.temp    = rx_data;

    temp_log_buffer_log_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .re    (do_pop),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_pop && !full) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

    // A clear coinciding with a write reloads the stats from that sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_temp <= MIN_INIT;
            max_temp <= MAX_INIT;
            overflow <= 1'b0;
        end else if (clr_stats) begin
            min_temp <= do_wr ? rx_data : MIN_INIT;
            max_temp <= do_wr ? rx_data : MAX_INIT;
            overflow <= overwrite;
        end else begin
            if (do_wr) begin
                min_temp <= umin(min_temp, rx_data);
                max_temp <= umax(max_temp, rx_data);
            end
            if (overwrite) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_temp_log_buffer.sv
// Directed bench for temp_log_buffer with hand-computed expectations.
module tb_temp_log_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [4:0]  hours = '0;
    logic [5:0]  minutes = '0;
    logic        rd_req = 1'b0;
    logic [18:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        clr_stats = 1'b0;
    logic [7:0]  min_temp;
    logic [7:0]  max_temp;

    int total = 0;
    int bad = 0;

    temp_log_buffer #(.DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .hours     (hours),
        .minutes   (minutes),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .clr_stats (clr_stats),
        .min_temp  (min_temp),
        .max_temp  (max_temp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int h, input int m, input int t);
        logic [4:0] hh;
        logic [5:0] mm;
        logic [7:0] tt;
        hh = h[4:0];
        mm = m[5:0];
        tt = t[7:0];
        return {13'b0, hh, mm, tt};
    endfunction

    task automatic wr(input int t);
        rx_valid = 1'b1;
        rx_data  = t[7:0];
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check({tag, "_vld"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), exp);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_rdvld", 32'(rd_valid), 32'd0);
        check("rst_rddata", 32'(rd_data), 32'd0);
        check("rst_min", 32'(min_temp), 32'hFF);
        check("rst_max", 32'(max_temp), 32'h00);
        reset = 1'b0;
        tick();

        // Three writes at 10:05 then three pops
        hours = 5'd10;
        minutes = 6'd5;
        wr(25);
        wr(30);
        wr(18);
        check("t1_count", 32'(count), 32'd3);
        check("t1_min", 32'(min_temp), 32'd18);
        check("t1_max", 32'(max_temp), 32'd30);
        pop_chk("t1_pop0", ent(10, 5, 25));
        pop_chk("t1_pop1", ent(10, 5, 30));
        pop_chk("t1_pop2", ent(10, 5, 18));
        check("t1_empty", 32'(empty), 32'd1);
        tick();
        check("t1_vld_once", 32'(rd_valid), 32'd0);

        // Fill 0..15, then overwrite with 100, 101
        for (int i = 0; i < 16; i++) wr(i);
        check("t2_full16", 32'(full), 32'd1);
        check("t2_ovf_pre", 32'(overflow), 32'd0);
        wr(100);
        wr(101);
        check("t2_full", 32'(full), 32'd1);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_count", 32'(count), 32'd16);
        check("t2_min", 32'(min_temp), 32'd0);
        check("t2_max", 32'(max_temp), 32'd101);
        for (int i = 2; i < 16; i++) pop_chk("t2_pop", ent(10, 5, i));
        pop_chk("t2_pop100", ent(10, 5, 100));
        pop_chk("t2_pop101", ent(10, 5, 101));
        check("t2_empty", 32'(empty), 32'd1);

        // Clear stats, fill, then write+pop together while full
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("t3_clr_ovf", 32'(overflow), 32'd0);
        check("t3_clr_min", 32'(min_temp), 32'hFF);
        check("t3_clr_max", 32'(max_temp), 32'h00);
        for (int i = 0; i < 16; i++) wr(i);
        hours = 5'd23;
        minutes = 6'd59;
        rx_valid = 1'b1;
        rx_data = 8'd77;
        rd_req = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd_req = 1'b0;
        check("t3_vld", 32'(rd_valid), 32'd1);
        check("t3_data", 32'(rd_data), ent(10, 5, 0));
        check("t3_count", 32'(count), 32'd16);
        check("t3_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) pop_chk("t3_pop", ent(10, 5, i));
        pop_chk("t3_pop77", ent(23, 59, 77));
        check("t3_empty", 32'(empty), 32'd1);

        // Write+pop together on empty: no bypass
        hours = 5'd8;
        minutes = 6'd30;
        rx_valid = 1'b1;
        rx_data = 8'd40;
        rd_req = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd_req = 1'b0;
        check("t4_novld", 32'(rd_valid), 32'd0);
        check("t4_count", 32'(count), 32'd1);
        check("t4_hold", 32'(rd_data), ent(23, 59, 77));
        check("t4_max", 32'(max_temp), 32'd77);
        pop_chk("t4_pop40", ent(8, 30, 40));

        // clr_stats coinciding with a write reloads min/max
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        wr(50);
        wr(60);
        check("t5_min", 32'(min_temp), 32'd50);
        check("t5_max", 32'(max_temp), 32'd60);
        clr_stats = 1'b1;
        wr(55);
        clr_stats = 1'b0;
        check("t5_clr_min", 32'(min_temp), 32'd55);
        check("t5_clr_max", 32'(max_temp), 32'd55);
        check("t5_count", 32'(count), 32'd3);
        pop_chk("t5_pop50", ent(8, 30, 50));
        pop_chk("t5_pop60", ent(8, 30, 60));
        pop_chk("t5_pop55", ent(8, 30, 55));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t5_empty_novld", 32'(rd_valid), 32'd0);
        check("t5_empty_hold", 32'(rd_data), ent(8, 30, 55));

        // Overwrite coinciding with clr_stats keeps overflow set
        for (int i = 0; i < 16; i++) wr(i);
        clr_stats = 1'b1;
        wr(200);
        clr_stats = 1'b0;
        check("t6_ovf", 32'(overflow), 32'd1);
        check("t6_min", 32'(min_temp), 32'd200);
        check("t6_max", 32'(max_temp), 32'd200);
        check("t6_count16", 32'(count), 32'd16);
        rd_req = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        rd_req = 1'b0;
        check("t6_count5", 32'(count), 32'd5);

        // Asynchronous reset in the middle of a pop
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t7_vld_pre", 32'(rd_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t7_count", 32'(count), 32'd0);
        check("t7_vld", 32'(rd_valid), 32'd0);
        check("t7_empty", 32'(empty), 32'd1);
        check("t7_ovf", 32'(overflow), 32'd0);
        check("t7_min", 32'(min_temp), 32'hFF);
        check("t7_max", 32'(max_temp), 32'h00);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
